// File: rtl/truth_sweep.sv
// rtl/truth_sweep.sv - truth-table sweeper for a 3-input combinational DUT
// Optional result compare enabled by defining SWEEP_CHECK_EN.
module truth_sweep #(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out
`ifdef SWEEP_CHECK_EN
  ,
  input  logic [7:0] expected,
  output logic       mismatch
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     state, state_n;
  logic [2:0] idx;
  logic [7:0] hold_cnt;
  logic [2:0] abc;
  logic       accept, clear, capture;
  logic [7:0] table_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    clear   = 1'b0;
    capture = 1'b0;
    table_n = table_out;
    table_n[idx] = y;
    case (state)
      IDLE: begin
        if (abort) clear = 1'b1;
        else if (start) begin
          accept  = 1'b1;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          clear   = 1'b1;
          state_n = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          capture = 1'b1;
          if (idx == 3'd7) state_n = DONE;
        end
      end
      DONE: begin
        if (abort) clear = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // abc mirrors idx while driving and is forced to 000 outside DRIVE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 3'd0;
      hold_cnt  <= 8'd0;
      abc       <= 3'd0;
      table_out <= 8'd0;
    end else if (accept || clear) begin
      idx       <= 3'd0;
      hold_cnt  <= 8'd0;
      abc       <= 3'd0;
      table_out <= 8'd0;
    end else if (state == DRIVE) begin
      if (capture) begin
        table_out <= table_n;
        hold_cnt  <= 8'd0;
        if (idx != 3'd7) begin
          idx <= idx + 3'd1;
          abc <= idx + 3'd1;
        end else begin
          idx <= 3'd0;
          abc <= 3'd0;
        end
      end else begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

`ifdef SWEEP_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        mismatch <= 1'b0;
    else if (accept || clear)          mismatch <= 1'b0;
    else if (capture && idx == 3'd7)   mismatch <= (table_n != expected);
  end
`endif

  assign a    = abc[2];
  assign b    = abc[1];
  assign c    = abc[0];
  assign busy = (state == DRIVE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_truth_sweep.sv
// tb/tb_truth_sweep.sv - self-checking bench for truth_sweep (HOLD=2 and HOLD=1 instances)
module tb_truth_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start2 = 1'b0, abort2 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic a2, b2, c2, y2, busy2, done2;
  logic a1, b1, c1, y1, busy1, done1;
  logic [7:0] tbl2, tbl1;
`ifdef SWEEP_CHECK_EN
  logic [7:0] exp2 = 8'h96, exp1 = 8'h80;
  logic       mis2, mis1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y2 = a2 ^ b2 ^ c2;
  assign y1 = a1 & b1 & c1;

  truth_sweep #(.HOLD(2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .a(a2), .b(b2), .c(c2), .y(y2), .busy(busy2), .done(done2), .table_out(tbl2)
`ifdef SWEEP_CHECK_EN
    , .expected(exp2), .mismatch(mis2)
`endif
  );

  truth_sweep #(.HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .a(a1), .b(b1), .c(c1), .y(y1), .busy(busy1), .done(done1), .table_out(tbl1)
`ifdef SWEEP_CHECK_EN
    , .expected(exp1), .mismatch(mis1)
`endif
  );

  typedef struct {
    logic [2:0] abc;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tv2[18];
  vec_t tv1[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // raises start for exactly one edge; returns #1 after that edge (edge 0)
  task automatic pulse_start2();
    @(negedge clk) start2 = 1'b1;
    @(posedge clk) #1 start2 = 1'b0;
  endtask

  task automatic pulse_start1();
    @(negedge clk) start1 = 1'b1;
    @(posedge clk) #1 start1 = 1'b0;
  endtask

  task automatic wait_done2(input string name);
    int n = 0;
    while (done2 !== 1'b1 && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    chk(name, {31'd0, done2}, 32'd1);
  endtask

  initial begin
    // HOLD=2: vector k/2 for 16 cycles, then DONE, then IDLE
    for (int k = 0; k < 18; k++) begin
      tv2[k].abc  = (k < 16) ? 3'(k / 2) : 3'd0;
      tv2[k].busy = (k < 16);
      tv2[k].done = (k == 16);
    end
    for (int k = 0; k < 10; k++) begin
      tv1[k].abc  = (k < 8) ? 3'(k) : 3'd0;
      tv1[k].busy = (k < 8);
      tv1[k].done = (k == 8);
    end

    #12;
    chk("reset_busy", {31'd0, busy2}, 32'd0);
    chk("reset_done", {31'd0, done2}, 32'd0);
    chk("reset_abc", {29'd0, a2, b2, c2}, 32'd0);
    chk("reset_table", {24'd0, tbl2}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle_no_start", {31'd0, busy2}, 32'd0);

    // HOLD=2 xor sweep, with a stray start mid-sweep that must be ignored
    pulse_start2();
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(posedge clk) #1;
      if (k == 5) start2 = 1'b1;
      if (k == 6) start2 = 1'b0;
      chk($sformatf("h2_abc_%0d", k), {29'd0, a2, b2, c2}, {29'd0, tv2[k].abc});
      chk($sformatf("h2_busy_%0d", k), {31'd0, busy2}, {31'd0, tv2[k].busy});
      chk($sformatf("h2_done_%0d", k), {31'd0, done2}, {31'd0, tv2[k].done});
`ifdef SWEEP_CHECK_EN
      if (k == 16) chk("h2_mismatch_96", {31'd0, mis2}, 32'd0);
`endif
    end
    chk("h2_table", {24'd0, tbl2}, 32'h96);
    repeat (3) @(posedge clk);
    #1 chk("h2_table_hold", {24'd0, tbl2}, 32'h96);

    // HOLD=1 and sweep
    pulse_start1();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(posedge clk) #1;
      chk($sformatf("h1_abc_%0d", k), {29'd0, a1, b1, c1}, {29'd0, tv1[k].abc});
      chk($sformatf("h1_busy_%0d", k), {31'd0, busy1}, {31'd0, tv1[k].busy});
      chk($sformatf("h1_done_%0d", k), {31'd0, done1}, {31'd0, tv1[k].done});
    end
    chk("h1_table", {24'd0, tbl1}, 32'h80);

    // abort on the 5th vector
    pulse_start2();
    repeat (8) @(posedge clk);
    #1 chk("abort_pre_abc", {29'd0, a2, b2, c2}, 32'd4);
    chk("abort_pre_table", {24'd0, tbl2}, 32'h06);
    abort2 = 1'b1;
    @(posedge clk) #1 abort2 = 1'b0;
    chk("abort_busy", {31'd0, busy2}, 32'd0);
    chk("abort_table", {24'd0, tbl2}, 32'd0);
    chk("abort_abc", {29'd0, a2, b2, c2}, 32'd0);
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk) #1;
        if (done2) seen++;
      end
      chk("abort_no_done", seen, 32'd0);
    end

    // abort and start together in IDLE: abort wins
    @(negedge clk) begin start2 = 1'b1; abort2 = 1'b1; end
    @(posedge clk) #1 begin start2 = 1'b0; abort2 = 1'b0; end
    chk("abort_beats_start", {31'd0, busy2}, 32'd0);

`ifdef SWEEP_CHECK_EN
    exp2 = 8'h97;
`endif
    pulse_start2();
    wait_done2("restart_done");
    chk("restart_table", {24'd0, tbl2}, 32'h96);
`ifdef SWEEP_CHECK_EN
    chk("h2_mismatch_97", {31'd0, mis2}, 32'd1);
`endif
    @(posedge clk) #1 chk("done_one_cycle", {31'd0, done2}, 32'd0);

    // asynchronous reset mid-sweep
    pulse_start2();
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy2}, 32'd0);
    chk("rst_abc", {29'd0, a2, b2, c2}, 32'd0);
    chk("rst_table", {24'd0, tbl2}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    begin
      int act = 0;
      for (int k = 0; k < 25; k++) begin
        @(posedge clk) #1;
        if (busy2 || done2) act++;
      end
      chk("rst_stays_idle", act, 32'd0);
    end

    // start held high: done every 8*HOLD+2 = 10 cycles for HOLD=1
    begin
      int t[3];
      int n = 0;
      int cyc = 0;
      @(negedge clk) start1 = 1'b1;
      while (n < 3 && cyc < 200) begin
        @(posedge clk) #1;
        cyc++;
        if (done1) begin
          t[n] = cyc;
          n++;
        end
      end
      chk("held_pulses", n, 32'd3);
      if (n == 3) begin
        chk("held_period_1", t[1] - t[0], 32'd10);
        chk("held_period_2", t[2] - t[1], 32'd10);
      end
      start1 = 1'b0;
      repeat (12) @(posedge clk);
      #1 chk("held_table", {24'd0, tbl1}, 32'h80);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
